keypad_debounce: RTL and testbench

Debounce and press-event stage between `keypad_decoder` and `digit_mem` in the keypad datapath. It takes the raw per-cycle key code from the decoder and requires the code to be stable for a programmable number of clocks. It then emits exactly one strobe per physical press and enforces a debounced release before accepting another key. Its output lets `digit_mem` shift digits on `key_strobe` only, so contact bounce and multi-key glitches never double-enter a digit.

---
 rtl/keypad_debounce.sv | 130 +++++++++++++
 tb/tb_keypad_debounce.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/keypad_debounce.sv
// Keypad press debouncer: qualifies a stable key code, emits one strobe per press,
// and requires a debounced release before accepting another key. Auto-repeat: KEYPAD_DB_REPEAT_EN.
module keypad_debounce #(
  parameter int DB_CYCLES     = 20,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] k_raw,
  output logic       key_strobe,
  output logic [3:0] key_code,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

`ifdef KEYPAD_DB_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             strobe_nxt;
  logic [3:0]       code_nxt;
  logic             held_nxt;
  logic             valid, match;

  assign valid   = ~k_raw[4];
  assign match   = valid && (k_raw[3:0] == cand);
  // Saturating increment; terminal counts are always below CNT_MAX for legal widths.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cand       <= 4'h0;
      cnt        <= '0;
      key_strobe <= 1'b0;
      key_code   <= 4'h0;
      key_held   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      key_strobe <= strobe_nxt;
      key_code   <= code_nxt;
      key_held   <= held_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    strobe_nxt = 1'b0;
    code_nxt   = key_code;
    case (state)
      IDLE: begin
        if (valid) begin
          cand_nxt  = k_raw[3:0];
          cnt_nxt   = CNT_ONE;
          state_nxt = CONFIRM;
        end
      end
      CONFIRM: begin
        if (!match) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt  = HELD;
          strobe_nxt = 1'b1;
          code_nxt   = cand;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        // A second valid key rolled on while held is ignored outright.
        if (match) begin
          if (REPEAT_EN) begin
            if (cnt == REP_LAST) begin
              strobe_nxt = 1'b1;
              cnt_nxt    = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end else if (!valid) begin
          state_nxt = RELEASE;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE: begin
        if (match) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (valid) begin
          // Another key restarts the release qualification, never a new press.
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    held_nxt = (state_nxt == HELD) || (state_nxt == RELEASE);
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce (DB_CYCLES=4, REPEAT_CYCLES=6): vector table plus reset/hold sequences.
module tb_keypad_debounce;

`ifdef KEYPAD_DB_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    logic [4:0] k;
    logic       stb;
    logic [3:0] code;
    logic       held;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] k_raw = 5'h10;
  logic       key_strobe;
  logic [3:0] key_code;
  logic       key_held;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  keypad_debounce #(.DB_CYCLES(4), .REPEAT_CYCLES(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .k_raw(k_raw),
    .key_strobe(key_strobe), .key_code(key_code), .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic stb, input logic [3:0] code, input logic held);
    chk({name, ".strobe"}, {3'b0, key_strobe}, {3'b0, stb});
    chk({name, ".code"}, key_code, code);
    chk({name, ".held"}, {3'b0, key_held}, {3'b0, held});
  endtask

  task automatic add(input logic [4:0] k, input int n, input logic stb, input logic [3:0] code, input logic held);
    vec_t v;
    v.k = k; v.stb = stb; v.code = code; v.held = held;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Apply k for one edge, then sample 1 time unit later.
  task automatic step(input logic [4:0] k);
    k_raw = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Clean press, long hold (repeat strobe on the 10th sample only when enabled), release
    add(5'h10, 2, 0, 4'h0, 0);
    add(5'h05, 3, 0, 4'h0, 0);
    add(5'h05, 1, 1, 4'h5, 1);
    add(5'h05, 5, 0, 4'h5, 1);
    add(5'h05, 1, REP, 4'h5, 1);
    add(5'h10, 3, 0, 4'h5, 1);
    add(5'h10, 1, 0, 4'h5, 0);
    // Bounce on press
    for (int r = 0; r < 3; r++) begin
      add(5'h07, 2, 0, 4'h5, 0);
      add(5'h10, 2, 0, 4'h5, 0);
    end
    add(5'h07, 3, 0, 4'h5, 0);
    add(5'h07, 1, 1, 4'h7, 1);
    add(5'h07, 1, 0, 4'h7, 1);
    add(5'h10, 3, 0, 4'h7, 1);
    add(5'h10, 1, 0, 4'h7, 0);
    // Bounce on release
    add(5'h0A, 3, 0, 4'h7, 0);
    add(5'h0A, 1, 1, 4'hA, 1);
    add(5'h10, 2, 0, 4'hA, 1);
    add(5'h0A, 1, 0, 4'hA, 1);
    add(5'h10, 3, 0, 4'hA, 1);
    add(5'h10, 1, 0, 4'hA, 0);
    add(5'h10, 2, 0, 4'hA, 0);
    // Multi-key: C while 3 held is ignored; later clean C press is accepted
    add(5'h03, 3, 0, 4'hA, 0);
    add(5'h03, 1, 1, 4'h3, 1);
    add(5'h0C, 8, 0, 4'h3, 1);
    add(5'h10, 3, 0, 4'h3, 1);
    add(5'h10, 1, 0, 4'h3, 0);
    add(5'h0C, 3, 0, 4'h3, 0);
    add(5'h0C, 1, 1, 4'hC, 1);
    // Different key during release restarts the release count
    add(5'h10, 2, 0, 4'hC, 1);
    add(5'h05, 1, 0, 4'hC, 1);
    add(5'h10, 3, 0, 4'hC, 1);
    add(5'h10, 1, 0, 4'hC, 0);
    // Invalid flag with nonzero low bits is still "no key"
    add(5'h15, 2, 0, 4'hC, 0);

    // Reset state
    #3;
    chk_all("reset", 0, 4'h0, 0);
    #4 reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].k);
      chk_all($sformatf("vec%0d", i), tbl[i].stb, tbl[i].code, tbl[i].held);
    end

    // Reset during CONFIRM (cnt=2)
    step(5'h09);
    step(5'h09);
    chk_all("confirm_pre", 0, 4'hC, 0);
    #2 reset = 1'b0;
    #1 chk_all("rst_confirm", 0, 4'h0, 0);
    #1 reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(5'h09);
      chk_all($sformatf("post_rst1_e%0d", i), i == 4, (i >= 4) ? 4'h9 : 4'h0, i >= 4);
    end
    // Reset during HELD
    #2 reset = 1'b0;
    #1 chk_all("rst_held", 0, 4'h0, 0);
    #1 reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(5'h09);
      chk_all($sformatf("post_rst2_e%0d", i), i == 4, (i == 4) ? 4'h9 : 4'h0, i == 4);
    end
    for (int i = 1; i <= 4; i++) begin
      step(5'h10);
      chk_all($sformatf("rel9_e%0d", i), 0, 4'h9, i < 4);
    end

    // Long hold: single strobe, or one every 6 cycles with auto-repeat
    for (int i = 1; i <= 20; i++) begin
      step(5'h01);
      chk_all($sformatf("hold1_e%0d", i),
              (i == 4) || (REP && i > 4 && ((i - 4) % 6) == 0),
              (i >= 4) ? 4'h1 : 4'h9, i >= 4);
    end
    for (int i = 1; i <= 4; i++) begin
      step(5'h10);
      chk_all($sformatf("rel1_e%0d", i), 0, 4'h1, i < 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
